// File: rtl/aes_cipher_serializer_if.sv
// Byte-stream port bundle between the AES encrypt core, the serializer and the byte consumer.
// The slave side belongs to the serializer; the master side is the core/consumer side driving it.
interface aes_cipher_serializer_if #(
  parameter int NBYTES = 16
);
  logic                  load_i;
  logic [8*NBYTES-1:0]   cipher_i;
  logic                  byte_ready_i;
  logic [7:0]            byte_o;
  logic                  byte_valid_o;
  logic                  last_o;
  logic                  busy_o;
  logic                  done_o;

  modport master (
    output load_i, cipher_i, byte_ready_i,
    input  byte_o, byte_valid_o, last_o, busy_o, done_o
  );

  modport slave (
    input  load_i, cipher_i, byte_ready_i,
    output byte_o, byte_valid_o, last_o, busy_o, done_o
  );
endinterface

// File: rtl/aes_cipher_serializer.sv
// Captures a ciphertext block after a settle delay and emits it MSB byte first over valid/ready.
// First byte SETTLE_CYCLES+1 cycles after load; byte_o/last_o hold while the consumer stalls.
module aes_cipher_serializer #(
  parameter int NBYTES        = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  aes_cipher_serializer_if.slave bus
);
  localparam int W     = 8 * NBYTES;
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     shift_q, shift_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.load_i) begin
          if (SETTLE_CYCLES == 0) begin
            shift_d = bus.cipher_i;
            idx_d   = '0;
            state_d = SHIFT;
          end else begin
            cnt_d   = CNT_W'(SETTLE_CYCLES);
            state_d = SETTLE;
          end
        end
      end
      SETTLE: begin
        // The core output is only trusted on the final settle edge.
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          shift_d = bus.cipher_i;
          idx_d   = '0;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SHIFT: begin
        if (bus.byte_ready_i) begin
          shift_d = shift_q << 8;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status outputs are registered copies of the next-state decode.
    valid_d = (state_d == SHIFT);
    last_d  = (state_d == SHIFT) && (idx_d == LAST_IDX);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Shift register is all-zero whenever no byte is valid, so byte_o reads 0 then.
  assign bus.byte_o       = shift_q[W-1 -: 8];
  assign bus.byte_valid_o = valid_q;
  assign bus.last_o       = last_q;
  assign bus.busy_o       = busy_q;
  assign bus.done_o       = done_q;
endmodule

// File: tb/tb_aes_cipher_serializer.sv
// Scoreboard bench: stimulus pushes expected bytes, a negedge monitor pops them on each transfer.
module tb_aes_cipher_serializer;
  logic clk;
  logic rst_n;

  aes_cipher_serializer_if #(.NBYTES(16)) z ();
  aes_cipher_serializer_if #(.NBYTES(16)) m ();
  aes_cipher_serializer_if #(.NBYTES(16)) t ();

  aes_cipher_serializer #(.NBYTES(16), .SETTLE_CYCLES(0)) dut_z (.clk(clk), .rst_n(rst_n), .bus(z.slave));
  aes_cipher_serializer #(.NBYTES(16), .SETTLE_CYCLES(2)) dut_m (.clk(clk), .rst_n(rst_n), .bus(m.slave));
  aes_cipher_serializer #(.NBYTES(16), .SETTLE_CYCLES(3)) dut_t (.clk(clk), .rst_n(rst_n), .bus(t.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [8:0] qz[$];
  logic [8:0] qm[$];
  logic [8:0] qt[$];

  logic       prev_stall [3];
  logic [7:0] prev_byte  [3];
  logic       prev_last  [3];
  logic       prev_lx    [3];
  int         xfer_cnt   [3];

  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [7:0] C1_BYTES [16] = '{8'h69, 8'hc4, 8'he0, 8'hd8, 8'h6a, 8'h7b, 8'h04, 8'h30,
                                           8'hd8, 8'hcd, 8'hb7, 8'h80, 8'h70, 8'hb4, 8'hc5, 8'h5a};
  localparam logic PAT [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] xv(input int i);
    logic [7:0] b;
    b = i[7:0];
    return 128'h00112233445566778899aabbccddeeff ^ {16{b}};
  endfunction

  task automatic push_blk(input int id, input logic [127:0] c, input int nb);
    logic [8:0] e;
    for (int k = 0; k < nb; k++) begin
      e = {(k == 15), c[127 - 8*k -: 8]};
      case (id)
        0:       qz.push_back(e);
        1:       qm.push_back(e);
        default: qt.push_back(e);
      endcase
    end
  endtask

  task automatic push_c1();
    for (int k = 0; k < 16; k++) qm.push_back({(k == 15), C1_BYTES[k]});
  endtask

  task automatic mon(input int id, input logic vld, input logic rdy, input logic [7:0] b,
                     input logic lst, input logic dn);
    logic [8:0] e;
    logic       have;
    if (!rst_n) begin
      prev_stall[id] = 1'b0;
      prev_lx[id]    = 1'b0;
      return;
    end
    chk($sformatf("done_pulse[%0d]", id), dn, prev_lx[id]);
    if (!vld) begin
      chk($sformatf("idle_byte[%0d]", id), b, 8'h00);
      chk($sformatf("idle_last[%0d]", id), lst, 1'b0);
    end
    if (prev_stall[id]) begin
      chk($sformatf("stall_valid[%0d]", id), vld, 1'b1);
      chk($sformatf("stall_byte[%0d]", id), b, prev_byte[id]);
      chk($sformatf("stall_last[%0d]", id), lst, prev_last[id]);
    end
    prev_lx[id] = 1'b0;
    if (vld && rdy) begin
      have = 1'b0;
      e    = '0;
      case (id)
        0:       if (qz.size() > 0) begin have = 1'b1; e = qz.pop_front(); end
        1:       if (qm.size() > 0) begin have = 1'b1; e = qm.pop_front(); end
        default: if (qt.size() > 0) begin have = 1'b1; e = qt.pop_front(); end
      endcase
      total++;
      if (!have) begin
        bad++;
        $display("FAIL unexpected_xfer[%0d]: got byte %0h expected no transfer", id, b);
      end else begin
        chk($sformatf("xfer_byte[%0d]", id), b, e[7:0]);
        chk($sformatf("xfer_last[%0d]", id), lst, e[8]);
      end
      xfer_cnt[id]++;
      prev_lx[id] = lst;
    end
    prev_stall[id] = vld && !rdy;
    prev_byte[id]  = b;
    prev_last[id]  = lst;
  endtask

  always @(negedge clk) begin
    mon(0, z.byte_valid_o, z.byte_ready_i, z.byte_o, z.last_o, z.done_o);
    mon(1, m.byte_valid_o, m.byte_ready_i, m.byte_o, m.last_o, m.done_o);
    mon(2, t.byte_valid_o, t.byte_ready_i, t.byte_o, t.last_o, t.done_o);
  end

  function automatic logic vld_of(input int id);
    case (id)
      0:       return z.byte_valid_o;
      1:       return m.byte_valid_o;
      default: return t.byte_valid_o;
    endcase
  endfunction

  function automatic logic busy_of(input int id);
    case (id)
      0:       return z.busy_o;
      1:       return m.busy_o;
      default: return t.busy_o;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int id, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!vld_of(id) && k < 40);
    if (!vld_of(id)) begin
      total++;
      bad++;
      $display("FAIL valid_timeout[%0d]: got valid=0 required 1", id);
    end
  endtask

  task automatic wait_idle(input int id);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy_of(id) && n < 200);
    if (busy_of(id)) begin
      total++;
      bad++;
      $display("FAIL idle_timeout[%0d]: got busy=1 required 0", id);
    end
  endtask

  initial begin
    int k;
    int nv;
    int p;
    int base;
    for (int i = 0; i < 3; i++) begin
      prev_stall[i] = 1'b0;
      prev_byte[i]  = '0;
      prev_last[i]  = 1'b0;
      prev_lx[i]    = 1'b0;
      xfer_cnt[i]   = 0;
    end
    rst_n = 1'b0;
    z.load_i = 1'b0; z.cipher_i = '0; z.byte_ready_i = 1'b1;
    t.load_i = 1'b0; t.cipher_i = '0; t.byte_ready_i = 1'b1;
    m.cipher_i = C1; m.byte_ready_i = 1'b1;
    m.load_i = 1'b1;

    // Reset held with load and ready asserted.
    tick();
    tick();
    @(negedge clk);
    chk("rst_busy", m.busy_o, 1'b0);
    chk("rst_valid", m.byte_valid_o, 1'b0);
    chk("rst_byte", m.byte_o, 8'h00);
    chk("rst_last", m.last_o, 1'b0);
    chk("rst_done", m.done_o, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m.load_i = 1'b0;
    tick();
    @(negedge clk);
    chk("rst_no_start", m.busy_o, 1'b0);

    // FIPS-197 C.1 ciphertext with continuous ready.
    push_c1();
    @(posedge clk); #1;
    m.load_i = 1'b1;
    tick();
    m.load_i = 1'b0;
    chk("load_busy", m.busy_o, 1'b1);
    wait_valid(1, k);
    chk("latency_s2", k, 3);
    nv = 0;
    for (int i = 0; i < 16; i++) begin
      if (m.byte_valid_o) nv++;
      @(negedge clk);
    end
    chk("no_bubbles", nv, 16);
    chk("valid_after_last", m.byte_valid_o, 1'b0);
    chk("done_after_last", m.done_o, 1'b1);
    wait_idle(1);

    // Backpressure pattern 1,0,0,1,0,1 repeating.
    push_c1();
    base = xfer_cnt[1];
    @(posedge clk); #1;
    m.load_i = 1'b1;
    tick();
    m.load_i = 1'b0;
    p = 0;
    do begin
      m.byte_ready_i = PAT[p % 6];
      p++;
      tick();
    end while (m.busy_o && p < 300);
    chk("bp_xfers", xfer_cnt[1] - base, 16);
    m.byte_ready_i = 1'b1;

    // Loads during SHIFT and DONE are ignored.
    push_c1();
    base = xfer_cnt[1];
    @(posedge clk); #1;
    m.load_i = 1'b1;
    tick();
    m.load_i = 1'b0;
    p = 0;
    for (int i = 0; i < 6; i++) begin
      m.byte_ready_i = PAT[p % 6];
      p++;
      tick();
    end
    m.load_i = 1'b1;
    m.cipher_i = '1;
    do begin
      m.byte_ready_i = PAT[p % 6];
      p++;
      tick();
    end while (!m.done_o && p < 300);
    chk("busy_in_done", m.busy_o, 1'b1);
    tick();
    m.load_i = 1'b0;
    m.cipher_i = C1;
    m.byte_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("no_second_block", m.busy_o, 1'b0);
    chk("busy_xfers", xfer_cnt[1] - base, 16);

    // Reset after the 5th transfer aborts; a fresh load restarts at byte 0.
    push_blk(1, C1, 5);
    @(posedge clk); #1;
    m.load_i = 1'b1;
    tick();
    m.load_i = 1'b0;
    wait_valid(1, k);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    m.byte_ready_i = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_valid", m.byte_valid_o, 1'b0);
    chk("abort_busy", m.busy_o, 1'b0);
    chk("abort_byte", m.byte_o, 8'h00);
    chk("abort_pending", qm.size(), 0);
    m.byte_ready_i = 1'b1;
    push_c1();
    @(posedge clk); #1;
    m.load_i = 1'b1;
    tick();
    m.load_i = 1'b0;
    wait_idle(1);

    // SETTLE_CYCLES=0 captures at the load edge.
    push_blk(0, xv(1), 16);
    @(posedge clk); #1;
    z.load_i = 1'b1;
    z.cipher_i = xv(1);
    tick();
    z.load_i = 1'b0;
    z.cipher_i = xv(2);
    wait_valid(0, k);
    chk("latency_s0", k, 1);
    z.cipher_i = xv(3);
    wait_idle(0);

    // SETTLE_CYCLES=3 captures at load edge + 3.
    push_blk(2, xv(13), 16);
    @(posedge clk); #1;
    t.load_i = 1'b1;
    t.cipher_i = xv(10);
    tick();
    t.load_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      t.cipher_i = xv(10 + i);
      if (i < 4) tick();
    end
    wait_idle(2);

    repeat (3) tick();
    chk("end_q_z", qz.size(), 0);
    chk("end_q_m", qm.size(), 0);
    chk("end_q_t", qt.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
